parking_gate_scheduler: RTL

//  Sequences the single shared lane barrier between entry and exit requesters and

---
 rtl/parking_pkg.sv | 17 +
 rtl/gate_timer.sv | 32 +++
 rtl/parking_gate_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared encodings for the parking lane gate scheduler.
// FSM state codes, direction constants and the default lot size.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam int DEF_TOTAL_SPACES = 200;

endpackage

// File: rtl/gate_timer.sv
// Open-gate watchdog: cleared on grant, counts open cycles, flags the last one.
// Only compiled when GATE_TIMEOUT_EN is defined.
`ifdef GATE_TIMEOUT_EN
module gate_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] L_LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != L_LAST) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expire = i_en & (r_cnt == L_LAST);

endmodule
`endif

// File: rtl/parking_gate_scheduler.sv
// Shared lane barrier sequencer with free-space accounting.
// Optional open-gate timeout enabled by defining GATE_TIMEOUT_EN.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int CAP_W        = 8,
    parameter int TOTAL_SPACES = DEF_TOTAL_SPACES,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic [CAP_W-1:0] free_spaces,
    output logic             full,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [CAP_W-1:0] L_TOTAL = CAP_W'(TOTAL_SPACES);

    state_t           r_state;
    logic             r_last_dir;
    logic [CAP_W-1:0] r_free;
    logic             r_gate;
    logic             r_gin;
    logic             r_gout;
    logic             r_full;
    logic             r_busy;
    logic             r_terr;

    logic             w_elig_in;
    logic             w_elig_out;
    logic             w_pick_in;
    logic             w_open;
    logic             w_load;
    logic             w_expire;
    logic [CAP_W-1:0] w_next_free;

    assign w_elig_in  = entry_req & ~r_full;
    assign w_elig_out = exit_req;
    // Contention goes to the direction not served last time
    assign w_pick_in  = w_elig_in & (~w_elig_out | (r_last_dir == DIR_OUT));
    assign w_open     = (r_state == OPEN_IN) | (r_state == OPEN_OUT);
    assign w_load     = (r_state == IDLE) & (w_elig_in | w_elig_out);

`ifdef GATE_TIMEOUT_EN
    gate_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_en    (w_open),
        .o_expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_next_free = r_free;
        if (r_state == OPEN_IN) begin
            w_next_free = r_free - CAP_W'(1);
        end else if (r_free != L_TOTAL) begin
            w_next_free = r_free + CAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_dir <= DIR_OUT;
            r_free     <= L_TOTAL;
            r_full     <= (L_TOTAL == '0);
            r_gate     <= 1'b0;
            r_gin      <= 1'b0;
            r_gout     <= 1'b0;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_terr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state    <= w_pick_in ? OPEN_IN : OPEN_OUT;
                        r_last_dir <= w_pick_in ? DIR_IN : DIR_OUT;
                        r_gate     <= 1'b1;
                        r_gin      <= w_pick_in;
                        r_gout     <= ~w_pick_in;
                        r_busy     <= 1'b1;
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    if (car_passed || w_expire) begin
                        r_state <= CLOSE;
                        r_gate  <= 1'b0;
                        r_gin   <= 1'b0;
                        r_gout  <= 1'b0;
                    end
                    if (car_passed) begin
                        r_free <= w_next_free;
                        r_full <= (w_next_free == '0);
                    end else if (w_expire) begin
                        r_terr <= 1'b1;
                    end
                end
                CLOSE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gate_open   = r_gate;
    assign grant_in    = r_gin;
    assign grant_out   = r_gout;
    assign free_spaces = r_free;
    assign full        = r_full;
    assign busy        = r_busy;
    assign timeout_err = r_terr;

endmodule
